// File: rtl/thin_window.sv
// thin_window: Zhang-Suen thinning sub-iteration stage with coordinate and frame tracking
module thin_window #(
  parameter int LINE_LEN  = 640,
  parameter int NUM_LINES = 480,
  parameter int XW        = 10,
  parameter int YW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          win_valid,
  input  logic          frame_start,
  input  logic          restart,
  input  logic          a0,
  input  logic          a1,
  input  logic          a2,
  input  logic          a3,
  input  logic          a4,
  input  logic          a5,
  input  logic          a6,
  input  logic          a7,
  input  logic          pix,
  output logic          pix_out,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          subiter,
  output logic          frame_done,
  output logic          changed
);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_LEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(NUM_LINES - 1);
  logic [7:0] nb8, ring;
  logic [XW-1:0] x_q, x_d, cx, x1_q;
  logic [YW-1:0] y_q, y_d, cy, y1_q;
  logic [3:0] nb_d, na_d, nb1_q, na1_q;
  logic c_d, bord_d;
  logic v1_q, fs1_q, pix1_q, c1_q, bord1_q;
  logic del, last, sticky_base;
  logic pix_out_q, pix_out_d, out_valid_q, frame_done_q, changed_q, changed_d;
  logic subiter_q, subiter_d, sticky_q, sticky_d, flip_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;
  assign nb8  = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign ring = {a0, a7, a6, a5, a4, a3, a2, a1};
  assign pix_out    = pix_out_q;
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign subiter    = subiter_q;
  assign frame_done = frame_done_q;
  assign changed    = changed_q;
  // Stage-1 combinational: neighbour count B, ring transitions A, C term, coordinates and border
  always_comb begin
    nb_d = 4'd0;
    na_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      nb_d = nb_d + {3'b0, nb8[i]};
      na_d = na_d + {3'b0, ~ring[i] & ring[(i + 1) % 8]};
    end
    c_d    = subiter_q ? (!(a1 & a3 & a7) & !(a1 & a5 & a7)) : (!(a1 & a3 & a5) & !(a3 & a5 & a7));
    cx     = frame_start ? '0 : x_q;
    cy     = frame_start ? '0 : y_q;
    bord_d = (cx == '0) | (cx == X_LAST) | (cy == '0) | (cy == Y_LAST);
    x_d    = (cx == X_LAST) ? '0 : cx + 1'b1;
    y_d    = (cx != X_LAST) ? cy : (cy == Y_LAST) ? '0 : cy + 1'b1;
  end
  // Stage-2 combinational: deletion decision and frame bookkeeping; restart overrides frame end
  always_comb begin
    del         = v1_q & pix1_q & (nb1_q >= 4'd2) & (nb1_q <= 4'd6) & (na1_q == 4'd1) & c1_q & !bord1_q;
    last        = v1_q & (x1_q == X_LAST) & (y1_q == Y_LAST);
    sticky_base = fs1_q ? 1'b0 : sticky_q;
    pix_out_d   = v1_q & pix1_q & !del;
    sticky_d    = restart ? 1'b0 : last ? 1'b0 : v1_q ? (sticky_base | del) : sticky_q;
    changed_d   = restart ? 1'b0 : last ? (sticky_base | del) : changed_q;
    subiter_d   = restart ? 1'b0 : flip_q ? ~subiter_q : subiter_q;
  end
  // Position counters plus the two pipeline stages; subiter flips one edge after frame_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      v1_q         <= 1'b0;
      fs1_q        <= 1'b0;
      pix1_q       <= 1'b0;
      c1_q         <= 1'b0;
      bord1_q      <= 1'b0;
      nb1_q        <= '0;
      na1_q        <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      pix_out_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
      changed_q    <= 1'b0;
      subiter_q    <= 1'b0;
      sticky_q     <= 1'b0;
      flip_q       <= 1'b0;
    end else begin
      if (win_valid) begin
        x_q <= x_d;
        y_q <= y_d;
      end
      v1_q         <= win_valid;
      fs1_q        <= win_valid & frame_start;
      pix1_q       <= pix;
      c1_q         <= c_d;
      bord1_q      <= bord_d;
      nb1_q        <= nb_d;
      na1_q        <= na_d;
      x1_q         <= cx;
      y1_q         <= cy;
      pix_out_q    <= pix_out_d;
      out_valid_q  <= v1_q;
      out_x_q      <= x1_q;
      out_y_q      <= y1_q;
      frame_done_q <= last;
      changed_q    <= changed_d;
      subiter_q    <= subiter_d;
      sticky_q     <= sticky_d;
      flip_q       <= last & ~restart;
    end
  end
endmodule

// File: tb/tb_thin_window.sv
// tb_thin_window: directed checks of thin_window on an 8x4 frame
module tb_thin_window;
  logic clk = 1'b0, rst = 1'b1, win_valid = 1'b0, frame_start = 1'b0, restart = 1'b0;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, a4 = 1'b0, a5 = 1'b0, a6 = 1'b0, a7 = 1'b0, pix = 1'b0;
  logic pix_out, out_valid, subiter, frame_done, changed;
  logic [2:0] out_x;
  logic [1:0] out_y;
  int n_tests = 0, n_fail = 0;
  logic [2:0] mx = 3'd0, px = 3'd0;
  logic [1:0] my = 2'd0, py = 2'd0;
  logic pv = 1'b0, ppo = 1'b0, pfd = 1'b0;
  thin_window #(.LINE_LEN(8), .NUM_LINES(4), .XW(3), .YW(2)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .frame_start(frame_start), .restart(restart),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .pix(pix),
    .pix_out(pix_out), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .subiter(subiter), .frame_done(frame_done), .changed(changed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Drive one cycle; dl says the window is deletable if it lands in the interior.
  // Checks the beat driven on the previous call (two edges of latency).
  task automatic step(input logic v, input logic fs, input logic [7:0] w, input logic p, input logic dl);
    logic [2:0] bx;
    logic [1:0] by;
    logic epo, efd;
    win_valid = v;
    frame_start = fs;
    {a7, a6, a5, a4, a3, a2, a1, a0} = w;
    pix = p;
    bx = fs ? 3'd0 : mx;
    by = fs ? 2'd0 : my;
    epo = p & ~(dl & bx != 3'd0 & bx != 3'd7 & by != 2'd0 & by != 2'd3);
    efd = v & bx == 3'd7 & by == 2'd3;
    if (v) begin
      mx = (bx == 3'd7) ? 3'd0 : bx + 3'd1;
      my = (bx != 3'd7) ? by : (by == 2'd3) ? 2'd0 : by + 2'd1;
    end
    tick();
    chk("out_valid", 16'(out_valid), 16'(pv));
    if (pv) begin
      chk("out_x", 16'(out_x), 16'(px));
      chk("out_y", 16'(out_y), 16'(py));
      chk("pix_out", 16'(pix_out), 16'(ppo));
    end
    chk("frame_done", 16'(frame_done), 16'(pfd));
    pv = v;
    px = bx;
    py = by;
    ppo = epo;
    pfd = efd;
  endtask
  initial begin
    tick();
    chk("reset_outs", 16'({pix_out, out_valid, out_x, out_y, subiter, frame_done, changed}), 16'd0);
    rst = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("subiter_start", 16'(subiter), 16'd0);
    step(1, 1, 8'h00, 0, 0);
    repeat (20) step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h07, 1, 1);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'h00, 0, 0);
    repeat (15) step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h07, 1, 1);
    step(1, 0, 8'h22, 1, 0);
    step(1, 0, 8'h8F, 1, 1);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'h07, 1, 1);
    for (int i = 1; i < 32; i++) step(1, 0, 8'h07, 1, 1);
    step(0, 0, 8'h00, 0, 0);
    chk("changed_f1", 16'(changed), 16'd1);
    step(0, 0, 8'h00, 0, 0);
    chk("subiter_f1", 16'(subiter), 16'd1);
    step(1, 1, 8'h00, 0, 0);
    repeat (20) step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h8F, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("subiter_hold", 16'(subiter), 16'd1);
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    win_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", 16'({pix_out, out_valid, out_x, out_y, subiter, frame_done, changed}), 16'd0);
    tick();
    rst = 1'b0;
    mx = 3'd0;
    my = 2'd0;
    pv = 1'b0;
    pfd = 1'b0;
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'h07, 1, 1);
    for (int i = 1; i < 10; i++) begin
      step(1, 0, 8'h07, 1, 1);
      if (i % 2 == 1) step(0, 0, 8'h00, 0, 0);
    end
    step(1, 1, 8'h00, 0, 0);
    for (int i = 1; i < 32; i++) begin
      step(1, 0, 8'h00, 0, 0);
      if (i % 5 == 0) step(0, 0, 8'h00, 0, 0);
    end
    step(0, 0, 8'h00, 0, 0);
    chk("changed_abort", 16'(changed), 16'd0);
    step(0, 0, 8'h00, 0, 0);
    chk("subiter_f2", 16'(subiter), 16'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("subiter_restart", 16'(subiter), 16'd0);
    chk("changed_restart", 16'(changed), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
